// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute sequencer for the 16-bit CPU core
//
// Fetches instructions over a req/ack port into ir. ir feeds the external
// combinational decoder. The sequencer then consumes the decoder's control
// fields to drive register writes, data-memory accesses, PC update and halt.
// It also counts retired instructions.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   run              start execution from IDLE
//   imem_req/addr    instruction fetch request, address (= pc)
//   imem_ack/data    fetch complete this cycle, fetched instruction
//   ir               instruction register (decoder input)
//   dec_*            decoder control fields: ld, mw, md, halt, bs, off
//   alu_zero         ALU zero flag for the current operands
//   rf_we            register file write strobe
//   link_sel         register write data comes from link_data
//   link_data        return address, always pc+1
//   dmem_req/we/ack  data memory request, write qualifier, completion
//   pc               program counter
//   halted           core halted
//   state            FSM state code
//   retired          retired-instruction count (wraps)
module cpu_sequencer #(
  parameter int PC_W     = 8,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_data,
  output logic [15:0]      ir,
  input  logic             dec_ld,
  input  logic             dec_mw,
  input  logic             dec_md,
  input  logic             dec_halt,
  input  logic [2:0]       dec_bs,
  input  logic [5:0]       dec_off,
  input  logic             alu_zero,
  output logic             rf_we,
  output logic             link_sel,
  output logic [PC_W-1:0]  link_data,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic [PC_W-1:0]  pc,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [PC_W-1:0] PC_RST = PC_W'(RESET_PC);

  state_t          st;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] pc_next;
  logic            mem_op;
  logic            exec_retire;

  assign pc_inc = pc_r + PC_W'(1);
  // Offset is sign-extended to the PC width; wrap-around is intentional.
  assign tgt    = pc_inc + PC_W'($signed(dec_off));

  // Memory ops only exist in the bs=100 (no-branch) encoding.
  assign mem_op      = (dec_bs == 3'b100) && (dec_mw || (dec_ld && dec_md));
  // EXEC cycle that completes the instruction without going to MEM or HALT.
  assign exec_retire = (st == S_EXEC) && !dec_halt && !mem_op;

  always_comb begin
    pc_next = pc_inc;
    case (dec_bs)
      3'b000:  pc_next = alu_zero ? tgt : pc_inc;
      3'b001:  pc_next = alu_zero ? pc_inc : tgt;
      3'b010:  pc_next = tgt;
      3'b011:  pc_next = tgt;
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= S_IDLE;
      pc_r    <= PC_RST;
      ir      <= 16'h0000;
      retired <= '0;
    end else begin
      case (st)
        S_IDLE: begin
          if (run) st <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            ir <= imem_data;
            st <= S_DECODE;
          end
        end
        S_DECODE: begin
          st <= S_EXEC;
        end
        S_EXEC: begin
          if (dec_halt) begin
            st <= S_HALT;
          end else if (mem_op) begin
            st <= S_MEM;
          end else begin
            pc_r    <= pc_next;
            retired <= retired + CNT_W'(1);
            st      <= S_FETCH;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            pc_r    <= pc_inc;
            retired <= retired + CNT_W'(1);
            st      <= S_FETCH;
          end
        end
        S_HALT: begin
          st <= S_HALT;
        end
        default: st <= S_IDLE;
      endcase
    end
  end

  // Strobes are decoded from the registered state; the write strobes also
  // qualify on the decoder fields sampled in that same cycle.
  assign imem_req  = (st == S_FETCH);
  assign imem_addr = pc_r;
  assign dmem_req  = (st == S_MEM);
  assign dmem_we   = (st == S_MEM) && dec_mw;
  assign rf_we     = (exec_retire && (dec_ld || dec_bs == 3'b011))
                   || ((st == S_MEM) && dmem_ack && dec_ld);
  assign link_sel  = exec_retire && (dec_bs == 3'b011);
  assign link_data = pc_inc;
  assign pc        = pc_r;
  assign halted    = (st == S_HALT);
  assign state     = st;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - scoreboard testbench for cpu_sequencer
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_data = 16'h0000;
  logic [15:0] ir;
  logic        dec_ld = 0, dec_mw = 0, dec_md = 0, dec_halt = 0;
  logic [2:0]  dec_bs = 3'b100;
  logic [5:0]  dec_off = 6'h00;
  logic        alu_zero = 1'b0;
  logic        rf_we, link_sel;
  logic [7:0]  link_data;
  logic        dmem_req, dmem_we;
  logic        dmem_ack = 1'b0;
  logic [7:0]  pc;
  logic        halted;
  logic [2:0]  state;
  logic [15:0] retired;

  cpu_sequencer #(.PC_W(8), .RESET_PC(0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .ir(ir),
    .dec_ld(dec_ld), .dec_mw(dec_mw), .dec_md(dec_md), .dec_halt(dec_halt),
    .dec_bs(dec_bs), .dec_off(dec_off), .alu_zero(alu_zero),
    .rf_we(rf_we), .link_sel(link_sel), .link_data(link_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .pc(pc), .halted(halted), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [1:0] K_F = 2'd0, K_M = 2'd1, K_W = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] s;
  } ev_t;

  ev_t         expq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_ir = 16'h0000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] s);
    ev_t e;
    e.kind = k; e.a = a; e.b = b; e.s = s;
    expq.push_back(e);
  endtask

  task automatic check_ev(input logic [1:0] k, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] s);
    ev_t e;
    ev_t g;
    g.kind = k; g.a = a; g.b = b; g.s = s;
    n_vec++;
    if (expq.size() == 0) begin
      n_err++;
      $display("FAIL event: unexpected kind=%0d a=%0h b=%0h s=%0d, nothing expected", k, a, b, s);
    end else begin
      e = expq.pop_front();
      if (e !== g) begin
        n_err++;
        $display("FAIL event: got kind=%0d a=%0h b=%0h s=%0d expected kind=%0d a=%0h b=%0h s=%0d",
                 g.kind, g.a, g.b, g.s, e.kind, e.a, e.b, e.s);
      end
    end
  endtask

  // Monitor: observes handshakes and register writes away from the clock edge.
  always @(negedge clk) begin
    if (imem_req && imem_ack) check_ev(K_F, imem_addr, 8'h00, 3'd0);
    if (dmem_req && dmem_ack) check_ev(K_M, {7'b0, dmem_we}, 8'h00, 3'd0);
    if (rf_we)                check_ev(K_W, {7'b0, link_sel}, link_data, state);
  end

  // Inputs change and registered outputs are checked 2 time units after posedge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs one instruction from FETCH. a = fetch address, xpc/xret = pc and
  // retired after completion, xw/xlink/xld = expected register write event.
  task automatic run_instr(
    input logic [15:0] data, input logic ld, input logic mw, input logic md,
    input logic hlt, input logic [2:0] bs, input logic [5:0] off, input logic z,
    input int idly, input int dly, input logic glitch, input logic [7:0] a,
    input logic xmem, input logic xw, input logic xlink, input logic [7:0] xld,
    input logic [7:0] xpc, input logic [15:0] xret);
    push(K_F, a, 8'h00, 3'd0);
    if (xmem) push(K_M, {7'b0, mw}, 8'h00, 3'd0);
    if (xw)   push(K_W, {7'b0, xlink}, xld, xmem ? 3'd4 : 3'd3);
    dec_ld = ld; dec_mw = mw; dec_md = md; dec_halt = hlt;
    dec_bs = bs; dec_off = off; alu_zero = z;
    for (int i = 0; i < idly; i++) begin
      chk("fetch_wait_state", state, 3'd1);
      chk("fetch_wait_req", imem_req, 1'b1);
      chk("fetch_wait_addr", imem_addr, a);
      chk("fetch_wait_ir", ir, exp_ir);
      tick();
    end
    imem_data = data; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0; imem_data = 16'hDEAD;
    exp_ir = data;
    chk("decode_state", state, 3'd2);
    chk("decode_ir", ir, data);
    if (glitch) begin
      imem_ack = 1'b1; imem_data = 16'hBEEF;
    end
    tick();
    imem_ack = 1'b0;
    chk("exec_state", state, 3'd3);
    chk("exec_ir", ir, data);
    if (hlt) begin
      tick();
      chk("halt_state", state, 3'd5);
      chk("halt_flag", halted, 1'b1);
      chk("halt_pc", pc, xpc);
      chk("halt_retired", retired, xret);
      return;
    end
    tick();
    if (xmem) begin
      for (int i = 0; i < dly; i++) begin
        chk("mem_wait_state", state, 3'd4);
        chk("mem_wait_req", dmem_req, 1'b1);
        chk("mem_wait_we", dmem_we, mw);
        chk("mem_wait_rf_we", rf_we, 1'b0);
        tick();
      end
      chk("mem_state", state, 3'd4);
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
    end
    chk("retire_state", state, 3'd1);
    chk("retire_pc", pc, xpc);
    chk("retire_count", retired, xret);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    chk("rst_state", state, 3'd0);
    chk("rst_pc", pc, 8'd0);
    chk("rst_ir", ir, 16'h0);
    chk("rst_retired", retired, 16'd0);
    chk("rst_strobes", {imem_req, rf_we, link_sel, dmem_req, dmem_we, halted}, 6'b0);
    rst = 1'b0;
    tick();
    chk("idle_hold", state, 3'd0);
    run = 1'b1;
    tick();
    run = 1'b0;
    chk("run_to_fetch", state, 3'd1);

    //          data     ld mw md h  bs      off    z  idly dly gl a     mem w  lk ld     pc     ret
    run_instr(16'hF0C1, 1, 0, 0, 0, 3'b100, 6'h00, 0, 0, 0, 0, 8'd0,   0, 1, 0, 8'd1,  8'd1,   16'd1);
    run_instr(16'h1003, 0, 0, 0, 0, 3'b010, 6'h03, 0, 0, 0, 0, 8'd1,   0, 0, 0, 8'd0,  8'd5,   16'd2);
    run_instr(16'h2001, 0, 0, 0, 0, 3'b000, 6'h3E, 1, 0, 0, 0, 8'd5,   0, 0, 0, 8'd0,  8'd4,   16'd3);
    run_instr(16'h2002, 0, 0, 0, 0, 3'b010, 6'h00, 0, 0, 0, 0, 8'd4,   0, 0, 0, 8'd0,  8'd5,   16'd4);
    run_instr(16'h2003, 0, 0, 0, 0, 3'b000, 6'h3E, 0, 0, 0, 0, 8'd5,   0, 0, 0, 8'd0,  8'd6,   16'd5);
    run_instr(16'h2004, 0, 0, 0, 0, 3'b001, 6'h3E, 1, 0, 0, 0, 8'd6,   0, 0, 0, 8'd0,  8'd7,   16'd6);
    run_instr(16'h2005, 0, 0, 0, 0, 3'b001, 6'h3E, 0, 0, 0, 0, 8'd7,   0, 0, 0, 8'd0,  8'd6,   16'd7);
    run_instr(16'h2006, 0, 0, 0, 0, 3'b010, 6'h03, 0, 0, 0, 0, 8'd6,   0, 0, 0, 8'd0,  8'd10,  16'd8);
    run_instr(16'h3007, 0, 0, 0, 0, 3'b011, 6'h03, 0, 0, 0, 0, 8'd10,  0, 1, 1, 8'd11, 8'd14,  16'd9);
    run_instr(16'h2008, 0, 0, 0, 0, 3'b010, 6'h20, 0, 0, 0, 0, 8'd14,  0, 0, 0, 8'd0,  8'd239, 16'd10);
    run_instr(16'h2009, 0, 0, 0, 0, 3'b010, 6'h1F, 0, 0, 0, 0, 8'd239, 0, 0, 0, 8'd0,  8'd15,  16'd11);
    run_instr(16'h400A, 1, 0, 1, 0, 3'b100, 6'h00, 0, 0, 3, 0, 8'd15,  1, 1, 0, 8'd16, 8'd16,  16'd12);
    run_instr(16'h500B, 0, 1, 0, 0, 3'b100, 6'h00, 0, 0, 0, 0, 8'd16,  1, 0, 0, 8'd0,  8'd17,  16'd13);
    run_instr(16'h600C, 0, 0, 0, 0, 3'b100, 6'h00, 0, 5, 0, 1, 8'd17,  0, 0, 0, 8'd0,  8'd18,  16'd14);
    run_instr(16'h200D, 0, 0, 0, 0, 3'b010, 6'h34, 0, 0, 0, 0, 8'd18,  0, 0, 0, 8'd0,  8'd7,   16'd15);
    run_instr(16'h700E, 1, 0, 0, 1, 3'b100, 6'h00, 0, 0, 0, 0, 8'd7,   0, 0, 0, 8'd0,  8'd7,   16'd15);

    run = 1'b1;
    tick(); tick();
    run = 1'b0;
    tick();
    chk("halt_run_ignored", state, 3'd5);
    chk("halt_pc_stays", pc, 8'd7);
    chk("halt_no_strobes", {imem_req, rf_we, dmem_req}, 3'b0);

    rst = 1'b1;
    #1;
    chk("rst_from_halt_state", state, 3'd0);
    chk("rst_from_halt_halted", halted, 1'b0);
    chk("rst_from_halt_pc", pc, 8'd0);
    tick();
    rst = 1'b0;
    exp_ir = 16'h0000;
    dec_halt = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    run_instr(16'hF0C1, 1, 0, 0, 0, 3'b100, 6'h00, 0, 0, 0, 0, 8'd0, 0, 1, 0, 8'd1, 8'd1, 16'd1);

    // Load that never completes; reset lands in the middle of MEM.
    push(K_F, 8'd1, 8'h00, 3'd0);
    dec_ld = 1; dec_md = 1; dec_mw = 0; dec_bs = 3'b100;
    imem_data = 16'h4111; imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    chk("mem_before_rst", state, 3'd4);
    chk("mem_before_rst_req", dmem_req, 1'b1);
    tick();
    #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_state", state, 3'd0);
    chk("rst_mid_mem_pc", pc, 8'd0);
    chk("rst_mid_mem_retired", retired, 16'd0);
    chk("rst_mid_mem_ir", ir, 16'h0);
    chk("rst_mid_mem_strobes", {imem_req, rf_we, link_sel, dmem_req, dmem_we, halted}, 6'b0);
    tick();
    rst = 1'b0;
    imem_ack = 1'b1; dmem_ack = 1'b1; imem_data = 16'h1234;
    tick(); tick();
    chk("late_ack_state", state, 3'd0);
    chk("late_ack_ir", ir, 16'h0);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    tick();
    chk("scoreboard_drained", expq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM for the 16-bit CPU core. It fetches instructions over a request/acknowledge instruction-memory port and holds the current instruction in IR, which drives the combinational instruction decoder. It consumes the decoder's control fields and sequences register-file writes, data-memory accesses, branch/PC update and halt. It also keeps a retired-instruction counter for debug.

Parameters:
PC_W, 8, program counter / instruction address width (must be >= 6)
RESET_PC, 0, PC value loaded on reset
CNT_W, 16, retired-instruction counter width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
run  input  1  start execution from IDLE
imem_req  output  1  instruction fetch request
imem_addr  output  PC_W  fetch address (= pc)
imem_ack  input  1  fetch data valid this cycle
imem_data  input  16  fetched instruction
ir  output  16  instruction register, drives decoder INST
dec_ld  input  1  decoder register write enable
dec_mw  input  1  decoder memory write
dec_md  input  1  decoder ALU/DRAM select
dec_halt  input  1  decoder halt
dec_bs  input  3  decoder branch select
dec_off  input  6  decoder branch offset, two's complement
alu_zero  input  1  ALU zero flag for current operands
rf_we  output  1  register file write strobe, one cycle
link_sel  output  1  register write data = link_data
link_data  output  PC_W  return address (pc+1)
dmem_req  output  1  data memory request
dmem_we  output  1  data memory write qualifier
dmem_ack  input  1  data memory done this cycle
pc  output  PC_W  program counter
halted  output  1  core halted
state  output  3  FSM state: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, HALT=5
retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset (async, any state, mid-fetch or mid-MEM included): state=IDLE, pc=RESET_PC, ir=0, retired=0. All strobes (imem_req, rf_we, link_sel, dmem_req, dmem_we) are 0, and halted=0. An in-flight ack after reset is ignored.
- IDLE: all strobes 0. run=1 -> FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ack. On the ack cycle: ir<=imem_data, go to DECODE. An ack outside FETCH is ignored.
- DECODE: one cycle, no strobes. Lets decoder outputs settle from the new ir. Next state is EXEC.
- EXEC: one cycle. All dec_* and alu_zero are sampled here. Priority order:
  1. dec_halt=1 -> HALT. pc is unchanged and rf_we=0.
  2. Memory op (dec_bs=100 and (dec_mw=1, or dec_ld=1 and dec_md=1)) -> MEM. No rf_we in EXEC.
  3. Otherwise: rf_we=dec_ld this cycle, the PC update is applied, retired+1, go to FETCH.
- PC update (all arithmetic modulo 2^PC_W; tgt = pc+1+sext(dec_off)):
  - bs=000: pc<=alu_zero ? tgt : pc+1
  - bs=001: pc<=alu_zero ? pc+1 : tgt
  - bs=010: pc<=tgt
  - bs=011: pc<=tgt, with rf_we=1, link_sel=1 and link_data=old pc+1 in the same cycle
  - bs=100 and the reserved codes 101/110/111: pc<=pc+1
- link_sel is 1 only in the EXEC cycle of bs=011. link_data is always pc+1 combinationally.
- MEM: dmem_req=1, dmem_we=dec_mw, held until dmem_ack. On the ack cycle: rf_we=dec_ld (load data captured that cycle), pc<=pc+1, retired+1, go to FETCH.
- HALT: halted=1, no strobes, run ignored. Only rst exits.
- retired wraps at 2^CNT_W. pc wraps from 2^PC_W-1 to 0.
- Minimum latency: 3 cycles per ALU/branch instruction with imem_ack in the first FETCH cycle, 4 cycles per memory instruction with dmem_ack in the first MEM cycle.

Test Plan:
1. Reset then run=1, instruction ALU op 0xF0C1 (dec_ld=1, bs=100), immediate acks -> states 1,2,3,1; rf_we high one cycle in EXEC; pc 0->1; retired=1.
2. Branch bs=000, dec_off=6'h3E (-2), pc=5: alu_zero=1 -> pc=4; repeated with alu_zero=0 -> pc=6. bs=001 gives the inverted outcomes.
3. bs=011, dec_off=3, pc=10 -> rf_we=1, link_sel=1, link_data=11 in EXEC; pc=14.
4. Load (dec_ld=1, dec_md=1, bs=100) with dmem_ack delayed 3 cycles -> dmem_req held 4 cycles, dmem_we=0, rf_we only on the ack cycle, pc+1. A store asserts dmem_we=1 and rf_we=0.
5. imem_ack delayed 5 cycles -> imem_req and imem_addr stable throughout, ir unchanged until ack. An ack pulse in DECODE is ignored.
6. dec_halt=1 at pc=7 -> HALT, halted=1, pc stays 7, run pulses ignored. rst asserted mid-MEM -> immediate IDLE, pc=RESET_PC, retired=0, all strobes 0.
